// File: rtl/piso_tx_if.sv
// Load handshake and serial-side signals of the piso_tx shift transmitter.
// The slave modport is the transmitter; the master modport is the word source / line observer.
interface piso_tx_if #(
    parameter int WIDTH = 4
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sout;
    logic             sframe;
    logic             done;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  sout,
        input  sframe,
        input  done,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output sout,
        output sframe,
        output done,
        output busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clk on sout.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    piso_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_TX_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             sout_r, sout_s;
    logic             sframe_r, sframe_s;
    logic             done_r, done_s;
    logic             handshake_s;

    // Bit that goes on the line first from a given register image.
    function automatic logic first_bit(input logic [WIDTH-1:0] d);
        if (MSB_FIRST) return d[WIDTH-1];
        else           return d[0];
    endfunction

    // Rotation (not shift) keeps every captured bit so parity can be taken at frame end.
    function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] d);
        if (MSB_FIRST) return {d[WIDTH-2:0], d[WIDTH-1]};
        else           return {d[0], d[WIDTH-1:1]};
    endfunction

`ifdef PISO_TX_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign handshake_s = bus.load_valid && (state_r == IDLE);

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        sout_s   = 1'b0;
        sframe_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_s  = SHIFT;
                    shreg_s  = bus.load_data;
                    cnt_s    = {CW{1'b0}};
                    sout_s   = first_bit(bus.load_data);
                    sframe_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST) begin
`ifdef PISO_TX_PARITY_EN
                    state_s  = PARITY;
                    sout_s   = even_parity(shreg_r);
                    sframe_s = 1'b1;
`else
                    state_s  = IDLE;
                    done_s   = 1'b1;
`endif
                end else begin
                    cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    shreg_s  = rotate(shreg_r);
                    sout_s   = first_bit(rotate(shreg_r));
                    sframe_s = 1'b1;
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_s = IDLE;
                done_s  = 1'b1;
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shreg_r  <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            sout_r   <= 1'b0;
            sframe_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            cnt_r    <= cnt_s;
            sout_r   <= sout_s;
            sframe_r <= sframe_s;
            done_r   <= done_s;
        end
    end

    assign bus.load_ready = (state_r == IDLE);
    assign bus.busy       = (state_r != IDLE);
    assign bus.sout       = sout_r;
    assign bus.sframe     = sframe_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a frame-level model (expected per-cycle output queue).
module tb_piso_tx;
    localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic sout;
        logic sframe;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) bm ();
    piso_tx_if #(.WIDTH(W)) bl ();

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));

    int   total = 0;
    int   bad   = 0;
    exp_t cur_m, cur_l;
    exp_t q_m[$];
    exp_t q_l[$];

    function automatic exp_t idle_e();
        exp_t e;
        e.sout = 1'b0; e.sframe = 1'b0; e.done = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
        return e;
    endfunction

    // Expected frame bit i for a word, in either transmission order.
    function automatic logic frame_bit(input bit msb, input logic [W-1:0] w, input int i);
        int unsigned v;
        v = w;
        if (i >= W) return logic'($countones(w) % 2);
        if (msb) return logic'((v >> (W - 1 - i)) & 1);
        else     return logic'((v >> i) & 1);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs, advance one edge, update the model, then sample away from the edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
        logic hs;
        exp_t e;
        bm.load_valid = v; bm.load_data = d;
        bl.load_valid = v; bl.load_data = d;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            q_m.delete(); q_l.delete();
            cur_m = idle_e(); cur_l = idle_e();
        end else begin
            hs = v && cur_m.ready;
            cur_m = (q_m.size() > 0) ? q_m.pop_front() : idle_e();
            cur_l = (q_l.size() > 0) ? q_l.pop_front() : idle_e();
            if (hs) begin
                for (int i = 0; i < W + PB; i++) begin
                    e.sframe = 1'b1; e.done = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
                    e.sout = frame_bit(1'b1, d, i); q_m.push_back(e);
                    e.sout = frame_bit(1'b0, d, i); q_l.push_back(e);
                end
                e = idle_e(); e.done = 1'b1;
                q_m.push_back(e); q_l.push_back(e);
                cur_m = q_m.pop_front();
                cur_l = q_l.pop_front();
            end
        end
        #1;
        chk("m_sout",   bm.sout,       cur_m.sout);
        chk("m_sframe", bm.sframe,     cur_m.sframe);
        chk("m_done",   bm.done,       cur_m.done);
        chk("m_busy",   bm.busy,       cur_m.busy);
        chk("m_ready",  bm.load_ready, cur_m.ready);
        chk("l_sout",   bl.sout,       cur_l.sout);
        chk("l_sframe", bl.sframe,     cur_l.sframe);
        chk("l_done",   bl.done,       cur_l.done);
        chk("l_busy",   bl.busy,       cur_l.busy);
        chk("l_ready",  bl.load_ready, cur_l.ready);
    endtask

    initial begin
        cur_m = idle_e();
        cur_l = idle_e();
        // Reset held for two edges.
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1);
        // Single word 1101.
        cyc(1'b1, 4'b1101, 1'b1);
        for (int i = 0; i < W + PB + 3; i++) cyc(1'b0, 4'b0000, 1'b1);
        // Parity-relevant word 1001.
        cyc(1'b1, 4'b1001, 1'b1);
        for (int i = 0; i < W + PB + 2; i++) cyc(1'b0, 4'b1111, 1'b1);
        // Back-to-back with load_valid held high; third word offered mid-frame.
        cyc(1'b1, 4'b1010, 1'b1);
        for (int i = 0; i < W + PB + 1; i++) cyc(1'b1, 4'b0110, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < W + PB + 4; i++) cyc(1'b0, 4'b0000, 1'b1);
        // Reset in cycle k+2 of a 1111 frame, then a fresh 0001 word.
        cyc(1'b1, 4'b1111, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 1'b1);
        for (int i = 0; i < W + PB + 3; i++) cyc(1'b0, 4'b0000, 1'b1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(logic'($urandom_range(0, 1)), 4'($urandom), logic'($urandom_range(0, 39) != 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out shift transmitter.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clk on a single serial line, with a frame qualifier and an end-of-word pulse.
- It is the transmit end paired with the team's serial-in/parallel-out receiver: sout/sframe drive that receiver's serial input.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word (high only in IDLE).
- load_data  input  WIDTH  parallel word to transmit.
- sout  output  1  serial data bit, registered.
- sframe  output  1  high on every cycle sout carries a frame bit, registered.
- done  output  1  one-cycle pulse after the last frame bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, shift register=0, bit counter=0, sout=0, sframe=0, done=0, busy=0, load_ready=1 after the edge.
- load_ready is combinational from state: 1 in IDLE, 0 otherwise.
- States: IDLE, SHIFT (plus PARITY when PARITY_EN is defined).
- IDLE:
  - sframe=0, sout=0.
  - Handshake = load_valid && load_ready at a rising edge.
  - On handshake: capture load_data into the shift register, clear the counter, go to SHIFT.
  - load_data is ignored without a handshake.
- Output timing: all outputs are registered. If the handshake occurs at edge k, the first bit is on sout with sframe=1 during cycle k+1.
- SHIFT:
  - One bit per cycle: bit WIDTH-1 down to 0 when MSB_FIRST=1; bit 0 up to WIDTH-1 when MSB_FIRST=0.
  - The counter increments each cycle.
  - After the WIDTH-th bit: go to IDLE, or to PARITY when PARITY_EN is defined.
  - sframe stays high for exactly WIDTH consecutive cycles without PARITY_EN.
- done:
  - 1 for exactly one cycle, the first cycle back in IDLE after the final frame bit.
  - sframe=0 and load_ready=1 in that same cycle.
- Back-to-back: a word offered during the done cycle is accepted at that edge. This gives exactly one idle (sframe=0) cycle between frames.
- load_valid during SHIFT/PARITY: no effect; the word is not captured, and the current frame is unaffected. load_valid may be held high across a frame.
- Counter width: clog2(WIDTH+1). No wrap occurs within a frame.
- Reset mid-frame: the frame is aborted immediately at that edge. No done pulse, outputs take reset values, no residual bits are emitted afterwards.
- busy = (state != IDLE).
- No other outputs change while in IDLE.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, a PARITY state drives one extra bit with sframe=1.
  - The bit is even parity: XOR of all WIDTH captured bits.
  - The frame is WIDTH+1 cycles, and done follows the parity cycle.
- Undefined: the PARITY state and parity logic do not exist, and the frame is WIDTH cycles.

Test Plan:
- Reset, WIDTH=4, MSB_FIRST=1:
  - Stimulus: hold rst_n=0 for 2 edges, then release.
  - Required: sout=0, sframe=0, done=0, busy=0, load_ready=1.
- Single word 4'b1101 accepted at edge k:
  - sout=1,1,0,1 in cycles k+1..k+4, with sframe=1 in those cycles only.
  - done=1 only in cycle k+5; busy=1 in k+1..k+4.
- MSB_FIRST=0, word 4'b1101:
  - sout=1,0,1,1 in cycles k+1..k+4, then done at k+5.
- Back-to-back, load_valid held high with 4'b1010 then 4'b0110:
  - Two 4-bit frames, 1,0,1,0 then 0,1,1,0.
  - Exactly one sframe=0 cycle between frames; two done pulses.
  - A third word presented mid-frame is not accepted until load_ready=1.
- Reset mid-frame:
  - Stimulus: rst_n=0 in cycle k+2 of the frame for 4'b1111.
  - Required: sframe=0 and sout=0 from the next edge, no done, load_ready=1.
  - A new word, 4'b0001, then transmits correctly.
- PISO_TX_PARITY_EN defined, WIDTH=4:
  - Word 4'b1101 gives sout=1,1,0,1,1, with sframe high for 5 cycles and done on the 6th cycle.
  - Word 4'b1001 gives a parity bit of 0.
